// File: rtl/challenge_sequencer.sv
// Buffers a host-supplied flag string and replays it into the flag-checker core,
// then classifies the core's win flag as pass / close / fail.
module challenge_sequencer #(
  parameter int DEPTH      = 64,
  parameter int EXPECT_LEN = 49,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_byte,
  input  logic          in_last,
  input  logic          start,
  input  logic          clear,
  output logic          busy,
  output logic [CW-1:0] len,
  output logic          chk_n_rst,
  output logic          chk_en,
  output logic [6:0]    chk_byte,
  input  logic          chk_win,
  output logic          done,
  output logic          pass,
  output logic          close,
  output logic          fail,
  output logic          err_overflow,
  output logic          err_nonascii
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {LOAD, CRST, GAP, STREAM, SAMPLE, REPORT} state_t;

  state_t        state;
  logic          loaded;
  logic [CW-1:0] idx;
  logic [6:0]    mem [DEPTH];
  logic          accept;

  assign in_ready = (state == LOAD) && !loaded && (len < CW'(DEPTH));
  assign accept   = in_ready && in_valid && !clear;

  // Plain array write port so the buffer maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[len[AW-1:0]] <= in_byte[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      len          <= '0;
      loaded       <= 1'b0;
      idx          <= '0;
      chk_n_rst    <= 1'b0;
      chk_en       <= 1'b0;
      chk_byte     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      close        <= 1'b0;
      fail         <= 1'b0;
      err_overflow <= 1'b0;
      err_nonascii <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          chk_n_rst <= 1'b1;
          chk_en    <= 1'b0;
          if (clear) begin
            len          <= '0;
            loaded       <= 1'b0;
            err_overflow <= 1'b0;
            err_nonascii <= 1'b0;
            pass         <= 1'b0;
            close        <= 1'b0;
            fail         <= 1'b0;
          end else if (start && loaded && (len != '0)) begin
            pass      <= 1'b0;
            close     <= 1'b0;
            fail      <= 1'b0;
            busy      <= 1'b1;
            chk_n_rst <= 1'b0;
            state     <= CRST;
          end else if (in_valid) begin
            if (in_ready) begin
              len <= len + 1'b1;
              if (in_byte[7]) err_nonascii <= 1'b1;
              if (in_last)    loaded       <= 1'b1;
            end else if (!loaded) begin
              // Full buffer with no terminator: drop the byte and freeze the string.
              err_overflow <= 1'b1;
              loaded       <= 1'b1;
            end
          end
        end
        CRST: begin
          chk_n_rst <= 1'b1;
          idx       <= '0;
          state     <= GAP;
        end
        GAP: begin
          chk_en   <= 1'b1;
          chk_byte <= mem[idx[AW-1:0]];
          idx      <= idx + 1'b1;
          state    <= STREAM;
        end
        STREAM: begin
          // idx runs one ahead of the byte on chk_byte; reaching len means the last byte is out.
          if (idx == len) begin
            chk_en <= 1'b0;
            state  <= SAMPLE;
          end else begin
            chk_byte <= mem[idx[AW-1:0]];
            idx      <= idx + 1'b1;
          end
        end
        SAMPLE: begin
          pass  <= chk_win && (len == CW'(EXPECT_LEN));
          close <= chk_win && (len != CW'(EXPECT_LEN));
          fail  <= !chk_win;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= REPORT;
        end
        REPORT: begin
          state <= LOAD;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_challenge_sequencer.sv
// Bench for challenge_sequencer: randomized strings against a queue-based reference
// and a simple behavioural checker core that wins when it has seen a chosen byte count.
module tb_challenge_sequencer;

  localparam int DEPTH      = 64;
  localparam int EXPECT_LEN = 49;
  localparam int CW         = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_byte = 8'h00;
  logic          in_last = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          busy;
  logic [CW-1:0] len;
  logic          chk_n_rst;
  logic          chk_en;
  logic [6:0]    chk_byte;
  logic          chk_win;
  logic          done;
  logic          pass;
  logic          close;
  logic          fail;
  logic          err_overflow;
  logic          err_nonascii;

  int errors = 0;
  int checks = 0;

  logic [6:0] ref_buf[$];
  bit         ref_loaded = 1'b0;
  bit         ref_ovf = 1'b0;
  bit         ref_nonascii = 1'b0;
  logic [7:0] stim[$];

  bit   win_mode = 1'b0;
  int   win_len = 0;
  int   m_cnt = 0;
  logic m_win = 1'b0;

  challenge_sequencer #(.DEPTH(DEPTH), .EXPECT_LEN(EXPECT_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .in_last(in_last), .start(start), .clear(clear),
    .busy(busy), .len(len), .chk_n_rst(chk_n_rst), .chk_en(chk_en),
    .chk_byte(chk_byte), .chk_win(chk_win), .done(done), .pass(pass),
    .close(close), .fail(fail), .err_overflow(err_overflow),
    .err_nonascii(err_nonascii)
  );

  always #5 clk = ~clk;

  // Checker core stand-in: win goes high right after it has consumed exactly win_len bytes.
  always @(posedge clk) begin
    if (!chk_n_rst) begin
      m_cnt <= 0;
      m_win <= 1'b0;
    end else if (chk_en) begin
      m_cnt <= m_cnt + 1;
      m_win <= win_mode && (m_cnt + 1 == win_len);
    end
  end
  assign chk_win = m_win;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    ref_buf.delete();
    ref_loaded = 1'b0;
    ref_ovf = 1'b0;
    ref_nonascii = 1'b0;
  endtask

  task automatic load_stim(input bit with_last);
    logic [CW-1:0] exp_len;
    for (int i = 0; i < stim.size(); i++) begin
      bit acc;
      acc = !ref_loaded && (ref_buf.size() < DEPTH);
      in_valid = 1'b1;
      in_byte  = stim[i];
      in_last  = with_last && (i == stim.size() - 1);
      checks++;
      if (in_ready !== acc) begin
        errors++;
        $display("FAIL in_ready byte %0d: got %b expected %b", i, in_ready, acc);
      end
      step();
      if (acc) begin
        ref_buf.push_back(stim[i][6:0]);
        if (stim[i][7]) ref_nonascii = 1'b1;
        if (in_last) ref_loaded = 1'b1;
      end else if (!ref_loaded) begin
        ref_ovf = 1'b1;
        ref_loaded = 1'b1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    exp_len = CW'(ref_buf.size());
    checks++;
    if (len !== exp_len) begin
      errors++;
      $display("FAIL load len: got %0d expected %0d", len, exp_len);
    end
    checks++;
    if ({err_overflow, err_nonascii} !== {ref_ovf, ref_nonascii}) begin
      errors++;
      $display("FAIL load errs: got ovf=%b nonascii=%b expected ovf=%b nonascii=%b",
               err_overflow, err_nonascii, ref_ovf, ref_nonascii);
    end
    $display("load %0d bytes offered, len=%0d ovf=%b nonascii=%b", stim.size(), len,
             err_overflow, err_nonascii);
  endtask

  task automatic do_run(input string name, input int clear_at);
    int            blen;
    bit            exp_win;
    bit            exp_pass;
    bit            exp_close;
    bit            exp_fail;
    logic [CW-1:0] exp_len;
    blen      = ref_buf.size();
    exp_len   = CW'(blen);
    exp_win   = win_mode && (blen == win_len);
    exp_pass  = exp_win && (blen == EXPECT_LEN);
    exp_close = exp_win && (blen != EXPECT_LEN);
    exp_fail  = !exp_win;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= blen + 6; n++) begin
      bit exp_en;
      int bi;
      if (n > 1) step();
      clear = 1'b0;
      exp_en = (n >= 3) && (n <= blen + 2);
      checks++;
      if (chk_en !== exp_en) begin
        errors++;
        $display("FAIL %s chk_en cycle %0d: got %b expected %b", name, n, chk_en, exp_en);
      end
      checks++;
      if (chk_n_rst !== (n != 1)) begin
        errors++;
        $display("FAIL %s chk_n_rst cycle %0d: got %b expected %b", name, n, chk_n_rst, n != 1);
      end
      if (exp_en || n == blen + 3) begin
        bi = exp_en ? n - 3 : blen - 1;
        checks++;
        if (chk_byte !== ref_buf[bi]) begin
          errors++;
          $display("FAIL %s chk_byte cycle %0d: got %h expected %h", name, n, chk_byte, ref_buf[bi]);
        end
      end
      checks++;
      if (done !== (n == blen + 4)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, n, done, n == blen + 4);
      end
      checks++;
      if (busy !== (n <= blen + 3)) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, n, busy, n <= blen + 3);
      end
      if (n >= blen + 4) begin
        checks++;
        if ({pass, close, fail} !== {exp_pass, exp_close, exp_fail}) begin
          errors++;
          $display("FAIL %s result cycle %0d: got pcf=%b%b%b expected %b%b%b", name, n,
                   pass, close, fail, exp_pass, exp_close, exp_fail);
        end
      end
      if (n == clear_at) clear = 1'b1;
    end
    clear = 1'b0;
    checks++;
    if (len !== exp_len) begin
      errors++;
      $display("FAIL %s len after run: got %0d expected %0d", name, len, exp_len);
    end
    $display("run %s len=%0d pass=%b close=%b fail=%b", name, blen, pass, close, fail);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({chk_n_rst, chk_en, busy, done, pass, close, fail, err_overflow, err_nonascii} !== 9'b0) begin
      errors++;
      $display("FAIL reset flags: got %b%b%b%b%b%b%b%b%b expected all 0", chk_n_rst, chk_en,
               busy, done, pass, close, fail, err_overflow, err_nonascii);
    end
    checks++;
    if (len !== '0 || chk_byte !== '0) begin
      errors++;
      $display("FAIL reset len/byte: got len=%0d byte=%h expected 0/00", len, chk_byte);
    end
    rst = 1'b0;
    step();
    checks++;
    if (chk_n_rst !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: got chk_n_rst=%b in_ready=%b expected 1/1", chk_n_rst, in_ready);
    end
    $display("reset done");
  endtask

  task automatic test_pass();
    do_clear();
    stim.delete();
    for (int i = 0; i < EXPECT_LEN; i++) stim.push_back(8'($urandom_range(32, 126)));
    load_stim(1'b1);
    win_mode = 1'b1;
    win_len  = EXPECT_LEN;
    do_run("pass49", 0);
  endtask

  task automatic test_close();
    string s;
    s = "pbctf{AHOY_PEKO_PEKO_shaak_nanodesu}";
    do_clear();
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    load_stim(1'b1);
    win_mode = 1'b1;
    win_len  = s.len();
    do_run("close36", 0);
  endtask

  task automatic test_fail_replay();
    win_mode = 1'b0;
    do_run("fail36", 0);
    do_run("replay36_clear_ignored", 5);
  endtask

  task automatic test_nonascii_early_start();
    do_clear();
    stim.delete();
    stim.push_back(8'hE1);
    load_stim(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || chk_n_rst !== 1'b1) begin
        errors++;
        $display("FAIL early start cycle %0d: got busy=%b chk_n_rst=%b expected 0/1", i, busy, chk_n_rst);
      end
      step();
    end
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(8'($urandom_range(32, 126)));
    load_stim(1'b1);
    win_mode = 1'b0;
    do_run("nonascii11", 0);
  endtask

  task automatic test_clear_priority();
    start = 1'b1;
    clear = 1'b1;
    step();
    start = 1'b0;
    clear = 1'b0;
    ref_buf.delete();
    ref_loaded = 1'b0;
    ref_ovf = 1'b0;
    ref_nonascii = 1'b0;
    checks++;
    if (busy !== 1'b0 || chk_n_rst !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear+start: got busy=%b chk_n_rst=%b in_ready=%b expected 0/1/1",
               busy, chk_n_rst, in_ready);
    end
    checks++;
    if (len !== '0 || {pass, close, fail, err_overflow, err_nonascii} !== 5'b0) begin
      errors++;
      $display("FAIL clear state: got len=%0d pcf=%b%b%b errs=%b%b expected all 0", len,
               pass, close, fail, err_overflow, err_nonascii);
    end
    $display("clear+start same cycle, len=%0d busy=%b", len, busy);
  endtask

  task automatic test_overflow();
    do_clear();
    stim.delete();
    for (int i = 0; i < DEPTH + 1; i++) stim.push_back(8'($urandom_range(32, 126)));
    load_stim(1'b0);
    checks++;
    if (err_overflow !== 1'b1 || len !== CW'(DEPTH) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow: got ovf=%b len=%0d in_ready=%b expected 1/%0d/0",
               err_overflow, len, in_ready, DEPTH);
    end
    win_mode = 1'b1;
    win_len  = DEPTH;
    do_run("full64", 0);
  endtask

  task automatic test_rst_midrun();
    bit done_seen;
    do_clear();
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'($urandom_range(32, 126)));
    load_stim(1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 2; n <= 13; n++) step();
    checks++;
    if (chk_en !== 1'b1 || chk_byte !== ref_buf[10]) begin
      errors++;
      $display("FAIL midrun idx10: got en=%b byte=%h expected 1/%h", chk_en, chk_byte, ref_buf[10]);
    end
    rst = 1'b1;
    step();
    checks++;
    if (chk_en !== 1'b0 || chk_n_rst !== 1'b0 || len !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst midrun: got en=%b n_rst=%b len=%0d busy=%b done=%b expected 0/0/0/0/0",
               chk_en, chk_n_rst, len, busy, done);
    end
    rst = 1'b0;
    ref_buf.delete();
    ref_loaded = 1'b0;
    ref_ovf = 1'b0;
    ref_nonascii = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0 || chk_n_rst !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after rst: got done_seen=%b chk_n_rst=%b in_ready=%b expected 0/1/1",
               done_seen, chk_n_rst, in_ready);
    end
    $display("rst mid-run at idx 10, len=%0d busy=%b", len, busy);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_close();
    test_fail_replay();
    test_nonascii_early_start();
    test_clear_priority();
    test_overflow();
    test_rst_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
